// File: rtl/sub_div_pkg.sv
// sub_div_pkg: shared width and FSM state encoding for the sequential restoring divider.
package sub_div_pkg;
  localparam int WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_ripple.sv
// sub_ripple: N-bit ripple-borrow subtractor built from full-subtractor cells, borrow-in tied to 0.
module sub_ripple
  import sub_div_pkg::*;
#(
  parameter int N = WIDTH + 1
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_bout
);
  logic [N:0] w_b;
  assign w_b[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fs
    assign o_diff[i] = i_a[i] ^ i_b[i] ^ w_b[i];
    assign w_b[i+1]  = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_b[i]);
  end
  assign o_bout = w_b[N];
endmodule

// File: rtl/sub_div_seq.sv
// sub_div_seq: unsigned restoring divider, one quotient bit per clock through a shared ripple subtractor.
// Optional SUB_DIV_SEQ_DIV0_FAST_EN: zero divisor skips the iterations and flags div0.
module sub_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);
  import sub_div_pkg::*;
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_q, r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_div0, r_fast;
  logic [WIDTH:0]   w_p, w_diff;
  logic [WIDTH-1:0] w_rem, w_qn;
  logic             w_bout, w_acc, w_last, w_zero, w_fin, w_unused;

`ifdef SUB_DIV_SEQ_DIV0_FAST_EN
  assign w_zero = divisor == '0;
`else
  assign w_zero = 1'b0;
`endif

  assign w_acc  = r_state == IDLE && start;
  assign w_last = r_state == RUN && r_cnt == '0;
  assign w_fin  = r_state == DONE && r_fast;
  // dividend register doubles as the quotient shift register
  assign w_p    = {r_rem, r_dvd[WIDTH-1]};
  assign w_rem  = w_bout ? w_p[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_qn   = {r_dvd[WIDTH-2:0], ~w_bout};
  assign w_unused = w_diff[WIDTH];

  sub_ripple #(.N(WIDTH + 1)) u_sub (
    .i_a   (w_p),
    .i_b   ({1'b0, r_dvs}),
    .o_diff(w_diff),
    .o_bout(w_bout)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb
    w_next = r_state == IDLE ? (start ? (w_zero ? DONE : RUN) : IDLE) :
             r_state == RUN  ? (r_cnt == '0 ? DONE : RUN) : IDLE;

  always_comb busy = r_state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      r_fast <= 1'b0;
    end else begin
      r_done <= w_last || w_fin;
      if (w_acc) begin
        r_dvd  <= dividend;
        r_dvs  <= divisor;
        r_rem  <= '0;
        r_cnt  <= CW'(WIDTH - 1);
        r_fast <= w_zero;
      end else if (r_state == RUN) begin
        r_dvd <= w_qn;
        r_rem <= w_rem;
        r_cnt <= r_cnt - 1'b1;
      end
      // fast zero-divisor results are published as the DONE state is left
      if (w_last) begin
        r_q    <= w_qn;
        r_r    <= w_rem;
        r_div0 <= 1'b0;
      end else if (w_fin) begin
        r_q    <= '1;
        r_r    <= r_dvd;
        r_div0 <= 1'b1;
      end
    end
  end

  assign done      = r_done;
  assign quotient  = r_q;
  assign remainder = r_r;
  assign div0      = r_div0;
endmodule

// File: tb/tb_sub_div_seq.sv
// tb_sub_div_seq: randomized and directed checks of sub_div_seq against an arithmetic reference model.
module tb_sub_div_seq;
`ifdef SUB_DIV_SEQ_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, div0;
  logic [15:0] quotient, remainder;
  logic [15:0] prev_q = '0, prev_r = '0;
  logic        prev_d = 1'b0;
  int          n_chk = 0, n_pass = 0;

  sub_div_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int glitch);
    logic [15:0] eq, er;
    logic        ed;
    int          lat, n;
    eq  = (b == 0) ? 16'hFFFF : a / b;
    er  = (b == 0) ? a : a % b;
    ed  = FAST && b == 0;
    lat = ed ? 1 : 16;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    chk("busy_run", busy, 1);
    chk("hold_q", quotient, prev_q);
    chk("hold_r", remainder, prev_r);
    n = 0;
    while (!done && n < 40) begin
      if (glitch > 0 && n == glitch - 1) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, lat);
    chk("quot", quotient, eq);
    chk("rem", remainder, er);
    chk("div0", div0, ed);
    if (!ed) chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("quot_hold", quotient, eq);
    prev_q = eq; prev_r = er; prev_d = ed;
  endtask

  initial begin
    int cnt, last, sel;
    logic [15:0] a, b;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_div0", div0, 0);
    rst = 1'b0;
    run_op(16'd100, 16'd7, 0);
    run_op(16'hFFFF, 16'd1, 0);
    run_op(16'd5, 16'd9, 0);
    run_op(16'h1234, 16'd0, 0);
    run_op(16'd100, 16'd7, 0);
    run_op(16'd100, 16'd7, 5);
    // reset mid-operation
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_quot", quotient, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_done_after_rst", cnt, 0);
    prev_q = '0; prev_r = '0; prev_d = 1'b0;
    run_op(16'd9, 16'd3, 0);
    // start held high: one operation every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    cnt = 0; last = -1;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        chk("b2b_quot", quotient, 333);
        chk("b2b_rem", remainder, 1);
        if (last >= 0) chk("b2b_interval", i - last, 18);
        last = i;
      end
    end
    start = 1'b0;
    chk("b2b_count", cnt, 3);
    cnt = 0;
    while (busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_drain", busy, 0);
    prev_q = 16'd333; prev_r = 16'd1; prev_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 3);
      a = 16'($urandom);
      b = sel == 0 ? 16'd0 : sel == 1 ? 16'($urandom_range(1, 15)) : 16'($urandom);
      run_op(a, b, (i % 4 == 0) ? $urandom_range(1, 12) : 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
